// File: rtl/rst_ctrl_pkg.sv
// rst_ctrl_pkg: shared state encoding and cause-bit layout for the reset controller
package rst_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_e;
  localparam int CAUSE_W    = 5;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_EXT  = 1;
  localparam int CAUSE_SW   = 2;
  localparam int CAUSE_WDOG = 3;
  localparam int CAUSE_DBG  = 4;
  localparam logic [CAUSE_W-1:0] CAUSE_RST = CAUSE_W'(1) << CAUSE_POR;
endpackage

// File: rtl/rst_debounce.sv
// rst_debounce: two-flop synchronizer plus consecutive-sample debounce filter for a bouncy pin
module rst_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          sync1_q, sync2_q, filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Count samples disagreeing with the filtered level; flip once enough arrive in a row
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) filt_d = ~filt_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  // Synchronizer and filter state; the pin idles high so everything resets to 1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end
  assign q_o = filt_q;
endmodule

// File: rtl/rst_ctrl.sv
// rst_ctrl: merges reset requests into a stretched, flop-driven reset with sticky cause tracking
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int STRETCH_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               test_mode_i,
  input  logic               ext_rst_ni,
  input  logic               sw_rst_req_i,
  input  logic               wdog_rst_req_i,
  input  logic               dbg_rst_req_i,
  input  logic               cause_clr_i,
  output logic               rst_no,
  output logic               rst_active_o,
  output logic [CAUSE_W-1:0] rst_cause_o,
  output logic [CNT_W-1:0]   rst_cnt_o
);
  localparam int SW = $clog2(STRETCH_CYCLES);
  localparam logic [SW-1:0] RELOAD = SW'(STRETCH_CYCLES - 1);
  logic               ext_filt, ext_req, pulse_req, level_req, any_req;
  state_e             state_q, state_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic               rst_q, rst_d, active_q, active_d, inc;
  logic [CAUSE_W-1:0] cause_q, cause_d, cause_set;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d, rcnt_base;

  rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ext_db (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ext_rst_ni),
    .q_o    (ext_filt)
  );

  assign ext_req   = ~ext_filt;
  assign pulse_req = sw_rst_req_i | wdog_rst_req_i;
  assign level_req = ext_req | dbg_rst_req_i;
  assign any_req   = pulse_req | level_req;

  // Stretch FSM: keep rst_q low until STRETCH_CYCLES after the last request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        rst_d = ~any_req;
        if (any_req) begin
          state_d = ASSERT;
          cnt_d   = RELOAD;
          inc     = 1'b1;
        end
      end
      ASSERT: begin
        if (pulse_req) cnt_d = RELOAD;
        else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (level_req) state_d = HOLD;
        else begin
          state_d = IDLE;
          rst_d   = 1'b1;
        end
      end
      HOLD: begin
        if (pulse_req || !level_req) begin
          state_d = ASSERT;
          cnt_d   = RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = state_d != IDLE;
  end

  // Sticky causes and saturating reset count; a same-edge set or increment beats the clear
  always_comb begin
    cause_set             = '0;
    cause_set[CAUSE_EXT]  = ext_req;
    cause_set[CAUSE_SW]   = sw_rst_req_i;
    cause_set[CAUSE_WDOG] = wdog_rst_req_i;
    cause_set[CAUSE_DBG]  = dbg_rst_req_i;
    cause_d               = (cause_clr_i ? '0 : cause_q) | cause_set;
    rcnt_base             = cause_clr_i ? '0 : rcnt_q;
    rcnt_d                = (inc && rcnt_base != '1) ? rcnt_base + 1'b1 : rcnt_base;
  end

  // All state is async-reset by the pad reset only
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rst_q    <= 1'b0;
      active_q <= 1'b0;
      cause_q  <= CAUSE_RST;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rst_q    <= rst_d;
      active_q <= active_d;
      cause_q  <= cause_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign rst_no       = test_mode_i ? rst_ni : rst_q;
  assign rst_active_o = active_q;
  assign rst_cause_o  = cause_q;
  assign rst_cnt_o    = rcnt_q;
endmodule

// File: tb/tb_rst_ctrl.sv
// tb_rst_ctrl: directed plus randomized checks of rst_ctrl against a timestamp-based reference model
module tb_rst_ctrl;
  localparam int S = 16;
  localparam int D = 4;
  logic       clk_i = 0, rst_ni = 0, test_mode_i = 0, ext_rst_ni = 1;
  logic       sw = 0, wd = 0, dbg = 0, clr = 0;
  logic       rst_no, act;
  logic [4:0] cause;
  logic [7:0] cnt;
  int n_cmp = 0, n_err = 0, lows = 0, first_low = -1, idx = 0;
  bit m_low, m_rst, m_hold, m_filt;
  int m_dl, m_cnt, now = 0;
  logic [4:0] m_cause;
  bit hist[$];

  always #5 clk_i = ~clk_i;

  rst_ctrl #(.STRETCH_CYCLES(S), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .ext_rst_ni(ext_rst_ni),
    .sw_rst_req_i(sw), .wdog_rst_req_i(wd), .dbg_rst_req_i(dbg), .cause_clr_i(clr),
    .rst_no(rst_no), .rst_active_o(act), .rst_cause_o(cause), .rst_cnt_o(cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_low = 0; m_rst = 0; m_hold = 0; m_filt = 1; m_cause = 5'b00001; m_cnt = 0;
    hist = {};
    for (int i = 0; i < 8; i++) hist.push_back(1'b1);
  endtask

  // Low phase ends at an absolute deadline S edges after the last pulse, or after a level request drops
  task automatic model_edge();
    bit er, pr, lr, all;
    er = !m_filt;
    pr = sw | wd;
    lr = er | dbg;
    m_cause = (clr ? 5'b0 : m_cause) | {dbg, wd, sw, er, 1'b0};
    if (clr) m_cnt = 0;
    if (!m_low) begin
      if (pr | lr) begin
        m_low = 1; m_hold = 0; m_dl = now + S;
        if (m_cnt < 255) m_cnt++;
      end
    end else if (pr) begin
      m_dl = now + S; m_hold = 0;
    end else if (m_hold) begin
      if (!lr) begin m_dl = now + S; m_hold = 0; end
    end else if (now >= m_dl) begin
      if (lr) m_hold = 1; else m_low = 0;
    end
    m_rst = !m_low;
    hist.push_front(ext_rst_ni);
    all = 1;
    for (int k = 0; k < D; k++) if (hist[2 + k] == m_filt) all = 0;
    if (all) m_filt = !m_filt;
    if (hist.size() > 16) void'(hist.pop_back());
    now++;
  endtask

  task automatic cyc(input bit s, input bit w, input bit c);
    sw = s; wd = w; clr = c;
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    sw = 0; wd = 0; clr = 0;
    check("rst_no", rst_no, test_mode_i ? rst_ni : m_rst);
    check("active", act, m_low);
    check("cause", cause, m_cause);
    check("cnt", cnt, m_cnt);
    if (!rst_no) begin
      lows++;
      if (first_low < 0) first_low = idx;
    end
    idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic mark();
    lows = 0; first_low = -1; idx = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    model_reset();
    check("rst_rst_no", rst_no, 0);
    check("rst_active", act, 0);
    check("rst_cause", cause, 5'b00001);
    check("rst_cnt", cnt, 0);
    rst_ni = 1;
    idle(9);
    mark();
    cyc(1, 0, 0);
    idle(19);
    check("sw_width", lows, S);
    check("sw_cause", cause, 5'b00101);
    check("sw_cnt", cnt, 1);

    cyc(0, 0, 1);
    mark();
    cyc(0, 1, 0);
    idle(4);
    cyc(0, 1, 0);
    idle(30);
    check("wd_width", lows, 5 + S);
    check("wd_cnt", cnt, 1);
    check("wd_cause", cause, 5'b01000);

    cyc(0, 0, 1);
    mark();
    dbg = 1;
    idle(40);
    dbg = 0;
    idle(30);
    check("dbg_width", lows, 40 + S);
    check("dbg_cause", cause, 5'b10000);

    cyc(0, 0, 1);
    ext_rst_ni = 0;
    idle(3);
    ext_rst_ni = 1;
    idle(10);
    check("glitch_cnt", cnt, 0);
    mark();
    ext_rst_ni = 0;
    idle(10);
    ext_rst_ni = 1;
    idle(40);
    check("ext_latency", first_low, 2 + D);
    check("ext_cause", cause, 5'b00010);
    check("ext_cnt", cnt, 1);

    cyc(1, 0, 1);
    check("clr_sw_cause", cause, 5'b00100);
    check("clr_sw_cnt", cnt, 1);
    idle(S + 1);
    for (int i = 0; i < 260; i++) begin
      cyc(1, 0, 0);
      idle(S + 1);
    end
    check("sat_cnt", cnt, 8'hFF);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) ext_rst_ni = ~ext_rst_ni;
      if ($urandom_range(0, 59) == 0) dbg = ~dbg;
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0);
    end
    ext_rst_ni = 1;
    dbg = 0;
    idle(60);

    test_mode_i = 1;
    @(negedge clk_i);
    rst_ni = 0;
    #1;
    check("tm_low", rst_no, 0);
    check("tm_cause", cause, 5'b00001);
    model_reset();
    #1;
    rst_ni = 1;
    #1;
    check("tm_high", rst_no, 1);
    cyc(1, 0, 0);
    check("tm_sw_rst_no", rst_no, 1);
    check("tm_sw_active", act, 1);
    idle(S + 4);
    test_mode_i = 0;

    dbg = 1;
    idle(5);
    #2;
    rst_ni = 0;
    #1;
    check("mid_rst_no", rst_no, 0);
    check("mid_active", act, 0);
    check("mid_cause", cause, 5'b00001);
    check("mid_cnt", cnt, 0);
    dbg = 0;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1;
    idle(S + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
